// File: rtl/warp_issue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sm_issue_pkg
// Shared types for the warp issue arbiter and its issue-unit peers.
//   unit_e       - execution unit code carried on req_unit / iss_unit
//   arb_state_e  - arbiter quiesce state (run / draining / idle)
//   NUM_UNITS    - number of credit-tracked execution units
//   CRED_W       - width of one unit credit counter (holds up to 15)
//   WARP_ID_W    - width of the zero-extended iss_warp_id field
// ---------------------------------------------------------------------------
package sm_issue_pkg;

    localparam int NUM_UNITS = 4;
    localparam int CRED_W    = 4;
    localparam int WARP_ID_W = 6;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_FPU = 2'd1,
        UNIT_LSU = 2'd2,
        UNIT_SFU = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/warp_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// warp_issue_arbiter_if
// Bundles the warp request side, the issue-unit handshake, credit returns
// and drain control of the warp issue arbiter.
//   slave  modport : arbiter side (requests/ready/credits/drain in)
//   master modport : environment side (warps + issue unit + drain control)
// Signals:
//   req_valid[NUM_WARPS]    per-warp instruction ready
//   req_unit[2*NUM_WARPS]   per-warp unit code, 2 bits per warp
//   grant[NUM_WARPS]        one-hot accept pulse
//   iss_valid/iss_warp_id/iss_unit, iss_ready   issue-unit handshake
//   cr_ret[4]               per-unit credit return pulses
//   drain_req / drain_done  quiesce request and acknowledge
//   cr_err                  sticky credit overflow flag
// ---------------------------------------------------------------------------
interface warp_issue_arbiter_if
    import sm_issue_pkg::*;
#(
    parameter int NUM_WARPS = 8
);
    logic [NUM_WARPS-1:0]   req_valid;
    logic [2*NUM_WARPS-1:0] req_unit;
    logic [NUM_WARPS-1:0]   grant;
    logic                   iss_valid;
    logic [WARP_ID_W-1:0]   iss_warp_id;
    logic [1:0]             iss_unit;
    logic                   iss_ready;
    logic [NUM_UNITS-1:0]   cr_ret;
    logic                   drain_req;
    logic                   drain_done;
    logic                   cr_err;

    modport slave (
        input  req_valid, req_unit, iss_ready, cr_ret, drain_req,
        output grant, iss_valid, iss_warp_id, iss_unit, drain_done, cr_err
    );

    modport master (
        output req_valid, req_unit, iss_ready, cr_ret, drain_req,
        input  grant, iss_valid, iss_warp_id, iss_unit, drain_done, cr_err
    );
endinterface

// File: rtl/warp_issue_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of mask found
// when scanning upward from ptr, wrapping at NUM_WARPS.
//   mask   - candidate vector
//   ptr    - search start index (must be < NUM_WARPS)
//   onehot - winner as one-hot (zero when mask is empty)
//   index  - winner index (zero when mask is empty)
//   found  - mask had at least one candidate
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_WARPS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_WARPS-1:0] mask,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_WARPS-1:0] onehot,
    output logic [IDX_W-1:0]     index,
    output logic                 found
);

    always_comb begin
        int cand;
        cand   = 0;
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            cand = (int'(ptr) + k) % NUM_WARPS;
            if (!found && mask[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/warp_issue_arbiter.sv
// ---------------------------------------------------------------------------
// warp_issue_arbiter
// Picks at most one ready warp per cycle and hands it to a registered issue
// stage, subject to per-unit in-flight credits and a drain/quiesce FSM.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - warp_issue_arbiter_if.slave (requests, issue handshake, credit
//          returns, drain control, cr_err)
// Parameters:
//   NUM_WARPS (2..32), UNIT_CREDITS (1..15), STARVE_LIMIT (1..255)
// Build option:
//   WARP_ISSUE_AGING_EN - when defined, per-warp age counters let a warp
//   that has waited STARVE_LIMIT eligible cycles override round-robin
//   (lowest index first). Undefined: pure round-robin, no age state.
// ---------------------------------------------------------------------------
module warp_issue_arbiter
    import sm_issue_pkg::*;
#(
    parameter int NUM_WARPS    = 8,
    parameter int UNIT_CREDITS = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    warp_issue_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(UNIT_CREDITS);

    arb_state_e            state_q, state_d;
    logic [CRED_W-1:0]     credit_q [NUM_UNITS];
    logic [CRED_W-1:0]     credit_d [NUM_UNITS];
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  iss_valid_q, iss_valid_d;
    logic [WARP_ID_W-1:0]  iss_warp_id_q, iss_warp_id_d;
    unit_e                 iss_unit_q, iss_unit_d;
    logic                  cr_err_q, cr_err_d;

    logic [NUM_WARPS-1:0]  eligible;
    logic [NUM_WARPS-1:0]  rr_onehot;
    logic [IDX_W-1:0]      rr_index;
    logic                  rr_found;
    logic [NUM_WARPS-1:0]  win_onehot;
    logic [IDX_W-1:0]      win_index;
    unit_e                 win_unit;
    logic                  loadable;
    logic                  do_grant;
    logic [NUM_WARPS-1:0]  grant_vec;
    logic [NUM_UNITS-1:0]  unit_take;
    logic                  all_home;

    // A warp may compete only while running and its target unit has credit.
    always_comb begin
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = bus.req_valid[w]
                        && (credit_q[bus.req_unit[2*w +: 2]] != '0)
                        && (state_q == ST_RUN);
        end
    end

    rr_pick #(
        .NUM_WARPS (NUM_WARPS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .mask   (eligible),
        .ptr    (rr_ptr_q),
        .onehot (rr_onehot),
        .index  (rr_index),
        .found  (rr_found)
    );

`ifdef WARP_ISSUE_AGING_EN
    localparam int AGE_W = 8;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0]     age_q [NUM_WARPS];
    logic [AGE_W-1:0]     age_d [NUM_WARPS];

    // Starved warps beat round-robin; scanning downward leaves the lowest
    // starved index as the final winner. A starved warp is eligible, so
    // rr_found already covers the "someone wins" condition.
    always_comb begin
        win_onehot = rr_onehot;
        win_index  = rr_index;
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            if (eligible[w] && (age_q[w] >= AGE_MAX)) begin
                win_onehot = NUM_WARPS'(1) << w;
                win_index  = IDX_W'(w);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            age_d[w] = age_q[w];
            if (grant_vec[w]) begin
                age_d[w] = '0;
            end else if (eligible[w] && (age_q[w] < AGE_MAX)) begin
                age_d[w] = age_q[w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (rst) begin
                age_q[w] <= '0;
            end else begin
                age_q[w] <= age_d[w];
            end
        end
    end
`else
    assign win_onehot = rr_onehot;
    assign win_index  = rr_index;
`endif

    // The issue register can take a new entry when empty or being drained
    // by the issue unit this cycle; grants happen only then.
    assign loadable  = !iss_valid_q || bus.iss_ready;
    assign do_grant  = loadable && rr_found && !rst;
    assign grant_vec = do_grant ? win_onehot : '0;
    assign win_unit  = unit_e'(bus.req_unit[2*int'(win_index) +: 2]);
    assign unit_take = do_grant ? (NUM_UNITS'(1) << win_unit) : '0;

    always_comb begin
        iss_valid_d   = iss_valid_q;
        iss_warp_id_d = iss_warp_id_q;
        iss_unit_d    = iss_unit_q;
        rr_ptr_d      = rr_ptr_q;
        if (loadable) begin
            iss_valid_d = do_grant;
            if (do_grant) begin
                iss_warp_id_d = WARP_ID_W'(win_index);
                iss_unit_d    = win_unit;
            end
        end
        if (do_grant) begin
            rr_ptr_d = (win_index == IDX_W'(NUM_WARPS - 1)) ? '0 : win_index + 1'b1;
        end
    end

    // A grant and a return to the same unit cancel. A return that would
    // overflow a full counter is dropped and flagged.
    always_comb begin
        cr_err_d = cr_err_q;
        all_home = 1'b1;
        for (int u = 0; u < NUM_UNITS; u++) begin
            credit_d[u] = credit_q[u];
            if (unit_take[u] && !bus.cr_ret[u]) begin
                credit_d[u] = credit_q[u] - 1'b1;
            end else if (bus.cr_ret[u] && !unit_take[u]) begin
                if (credit_q[u] == CRED_FULL) begin
                    cr_err_d = 1'b1;
                end else begin
                    credit_d[u] = credit_q[u] + 1'b1;
                end
            end
            if (credit_d[u] != CRED_FULL) begin
                all_home = 1'b0;
            end
        end
    end

    // Quiesce is judged on the values being loaded, so drain_done rises in
    // the same cycle the last credit lands.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.drain_req) begin
                    state_d = ST_RUN;
                end else if (!iss_valid_d && all_home) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!bus.drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            iss_valid_q   <= 1'b0;
            iss_warp_id_q <= '0;
            iss_unit_q    <= UNIT_ALU;
            cr_err_q      <= 1'b0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                credit_q[u] <= CRED_FULL;
            end
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            iss_valid_q   <= iss_valid_d;
            iss_warp_id_q <= iss_warp_id_d;
            iss_unit_q    <= iss_unit_d;
            cr_err_q      <= cr_err_d;
            for (int u = 0; u < NUM_UNITS; u++) begin
                credit_q[u] <= credit_d[u];
            end
        end
    end

    assign bus.grant       = grant_vec;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_warp_id = iss_warp_id_q;
    assign bus.iss_unit    = iss_unit_q;
    assign bus.drain_done  = (state_q == ST_IDLE);
    assign bus.cr_err      = cr_err_q;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_warp_issue_arbiter
// Directed scenarios for credits, hold, drain, reset and (optionally) aging,
// followed by randomized traffic checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_warp_issue_arbiter;
    localparam int NW = 8;
    localparam int UC = 4;
`ifdef WARP_ISSUE_AGING_EN
    localparam int SL = 3;
`else
    localparam int SL = 15;
`endif
    localparam int M_RUN = 0, M_DRAIN = 1, M_IDLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    warp_issue_arbiter_if #(.NUM_WARPS(NW)) bus ();

    warp_issue_arbiter #(
        .NUM_WARPS    (NW),
        .UNIT_CREDITS (UC),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model state
    int m_cred [4];
    int m_age  [NW];
    int m_rr, m_iss_id, m_iss_unit, m_mode;
    bit m_iss_v, m_err;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_unit  = '0;
        bus.iss_ready = 1'b1;
        bus.cr_ret    = '0;
        bus.drain_req = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic bit m_elig(int w);
        int u;
        u = int'(bus.req_unit[2*w +: 2]);
        return (m_mode == M_RUN) && bus.req_valid[w] && (m_cred[u] > 0);
    endfunction

    // Winner for this cycle, or -1 when nothing is granted.
    function automatic int m_pick();
        if (m_iss_v && !bus.iss_ready) return -1;
`ifdef WARP_ISSUE_AGING_EN
        for (int w = 0; w < NW; w++) if (m_elig(w) && m_age[w] >= SL) return w;
`endif
        for (int k = 0; k < NW; k++) if (m_elig((m_rr + k) % NW)) return (m_rr + k) % NW;
        return -1;
    endfunction

    function automatic void m_advance(int win);
        int  gu;
        bit  home;
        gu = (win >= 0) ? int'(bus.req_unit[2*win +: 2]) : -1;
        for (int w = 0; w < NW; w++) begin
            if (w == win) m_age[w] = 0;
            else if (m_elig(w) && m_age[w] < SL) m_age[w]++;
        end
        for (int u = 0; u < 4; u++) begin
            if (gu == u && !bus.cr_ret[u]) m_cred[u]--;
            else if (bus.cr_ret[u] && gu != u) begin
                if (m_cred[u] == UC) m_err = 1'b1;
                else m_cred[u]++;
            end
        end
        if (!m_iss_v || bus.iss_ready) begin
            m_iss_v = (win >= 0);
            if (win >= 0) begin
                m_iss_id   = win;
                m_iss_unit = gu;
            end
        end
        if (win >= 0) m_rr = (win + 1) % NW;
        home = 1'b1;
        for (int u = 0; u < 4; u++) if (m_cred[u] != UC) home = 1'b0;
        case (m_mode)
            M_RUN:   if (bus.drain_req) m_mode = M_DRAIN;
            M_DRAIN: if (!bus.drain_req) m_mode = M_RUN;
                     else if (!m_iss_v && home) m_mode = M_IDLE;
            default: if (!bus.drain_req) m_mode = M_RUN;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.req_valid = '1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h00) $display("FAIL rst_grant got=%h want=00", bus.grant); else n_pass++;
        n_chk++; if (bus.iss_valid !== 1'b0) $display("FAIL rst_iss_valid got=%b want=0", bus.iss_valid); else n_pass++;
        n_chk++; if (bus.iss_warp_id !== 6'd0) $display("FAIL rst_iss_warp_id got=%0d want=0", bus.iss_warp_id); else n_pass++;
        n_chk++; if (bus.iss_unit !== 2'd0) $display("FAIL rst_iss_unit got=%0d want=0", bus.iss_unit); else n_pass++;
        n_chk++; if (bus.drain_done !== 1'b0) $display("FAIL rst_drain_done got=%b want=0", bus.drain_done); else n_pass++;
        n_chk++; if (bus.cr_err !== 1'b0) $display("FAIL rst_cr_err got=%b want=0", bus.cr_err); else n_pass++;
        next_cycle();
        rst = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_credit_stall();
        logic [7:0] want;
        reset_dut();
        bus.req_valid = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            want = 8'h01 << k;
            @(negedge clk);
            n_chk++; if (bus.grant !== want) $display("FAIL stall_grant%0d got=%h want=%h", k, bus.grant, want); else n_pass++;
            if (k > 0) begin
                n_chk++; if (bus.iss_warp_id !== 6'(k - 1)) $display("FAIL stall_iss_id%0d got=%0d want=%0d", k, bus.iss_warp_id, k - 1); else n_pass++;
            end
            next_cycle();
        end
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h00) $display("FAIL stall_nocredit got=%h want=00", bus.grant); else n_pass++;
        n_chk++; if (bus.iss_warp_id !== 6'd3 || bus.iss_valid !== 1'b1) $display("FAIL stall_last_issue got=%b/%0d want=1/3", bus.iss_valid, bus.iss_warp_id); else n_pass++;
        next_cycle();
        bus.cr_ret = 4'b0001;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h00) $display("FAIL stall_ret_cycle got=%h want=00", bus.grant); else n_pass++;
        n_chk++; if (bus.iss_valid !== 1'b0) $display("FAIL stall_iss_clear got=%b want=0", bus.iss_valid); else n_pass++;
        next_cycle();
        bus.cr_ret = 4'b0000;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h10) $display("FAIL stall_resume got=%h want=10", bus.grant); else n_pass++;
        next_cycle();
        bus.req_valid = '0;
    endtask

    task automatic test_hold();
        reset_dut();
        bus.iss_ready = 1'b0;
        bus.req_valid = 8'h04;
        bus.req_unit  = 16'h0010;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h04) $display("FAIL hold_first_grant got=%h want=04", bus.grant); else n_pass++;
        next_cycle();
        bus.req_valid = 8'h0C;
        bus.req_unit  = 16'h0050;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (bus.grant !== 8'h00) $display("FAIL hold_grant%0d got=%h want=00", k, bus.grant); else n_pass++;
            n_chk++;
            if (bus.iss_valid !== 1'b1 || bus.iss_warp_id !== 6'd2 || bus.iss_unit !== 2'd1)
                $display("FAIL hold_iss%0d got=%b/%0d/%0d want=1/2/1", k, bus.iss_valid, bus.iss_warp_id, bus.iss_unit);
            else n_pass++;
            next_cycle();
        end
        bus.iss_ready = 1'b1;
        bus.req_valid = 8'h08;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.grant !== ((k < 3) ? 8'h08 : 8'h00))
                $display("FAIL hold_fpu_credit%0d got=%h want=%h", k, bus.grant, (k < 3) ? 8'h08 : 8'h00);
            else n_pass++;
            next_cycle();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_credit_same_cycle();
        reset_dut();
        bus.req_valid = 8'h02;
        bus.req_unit  = 16'h0008;
        bus.cr_ret    = 4'b0100;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h02) $display("FAIL same_grant got=%h want=02", bus.grant); else n_pass++;
        next_cycle();
        bus.req_valid = '0;
        @(negedge clk);
        n_chk++; if (bus.cr_err !== 1'b0) $display("FAIL same_no_err got=%b want=0", bus.cr_err); else n_pass++;
        next_cycle();
        bus.cr_ret = 4'b0000;
        @(negedge clk);
        n_chk++; if (bus.cr_err !== 1'b1) $display("FAIL same_lsu_full got=%b want=1", bus.cr_err); else n_pass++;
        reset_dut();
        bus.cr_ret = 4'b1000;
        @(negedge clk);
        n_chk++; if (bus.cr_err !== 1'b0) $display("FAIL sfu_err_early got=%b want=0", bus.cr_err); else n_pass++;
        next_cycle();
        bus.cr_ret = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (bus.cr_err !== 1'b1) $display("FAIL sfu_err_sticky%0d got=%b want=1", k, bus.cr_err); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_drain();
        reset_dut();
        bus.req_valid = 8'h03;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h01) $display("FAIL drain_g0 got=%h want=01", bus.grant); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h02) $display("FAIL drain_g1 got=%h want=02", bus.grant); else n_pass++;
        next_cycle();
        bus.req_valid = '0;
        bus.drain_req = 1'b1;
        next_cycle();
        bus.req_valid = 8'h01;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h00) $display("FAIL drain_block got=%h want=00", bus.grant); else n_pass++;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            bus.cr_ret = 4'b0001;
            @(negedge clk);
            n_chk++; if (bus.drain_done !== 1'b0) $display("FAIL drain_early%0d got=%b want=0", k, bus.drain_done); else n_pass++;
            next_cycle();
        end
        bus.cr_ret = 4'b0000;
        @(negedge clk);
        n_chk++; if (bus.drain_done !== 1'b1) $display("FAIL drain_done_rise got=%b want=1", bus.drain_done); else n_pass++;
        next_cycle();
        bus.drain_req = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h00) $display("FAIL drain_idle_block got=%h want=00", bus.grant); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_chk++; if (bus.drain_done !== 1'b0) $display("FAIL drain_exit got=%b want=0", bus.drain_done); else n_pass++;
        n_chk++; if (bus.grant !== 8'h01) $display("FAIL drain_resume got=%h want=01", bus.grant); else n_pass++;
        next_cycle();
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] want;
        reset_dut();
        bus.req_valid = 8'hFF;
        bus.iss_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h01) $display("FAIL midrst_pre got=%h want=01", bus.grant); else n_pass++;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.grant !== 8'h00) $display("FAIL midrst_grant got=%h want=00", bus.grant); else n_pass++;
        next_cycle();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.iss_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.iss_valid !== 1'b0) $display("FAIL midrst_iss got=%b want=0", bus.iss_valid); else n_pass++;
        next_cycle();
        bus.req_valid = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            want = (k < 4) ? (8'h01 << k) : 8'h00;
            @(negedge clk);
            n_chk++; if (bus.grant !== want) $display("FAIL midrst_after%0d got=%h want=%h", k, bus.grant, want); else n_pass++;
            next_cycle();
        end
        bus.req_valid = '0;
    endtask

`ifdef WARP_ISSUE_AGING_EN
    task automatic test_aging();
        logic [7:0] want;
        reset_dut();
        bus.req_unit = 16'h0400;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = (8'h01 << k) | 8'h20;
            want = (k < 3) ? (8'h01 << k) : 8'h20;
            @(negedge clk);
            n_chk++; if (bus.grant !== want) $display("FAIL aging%0d got=%h want=%h", k, bus.grant, want); else n_pass++;
            next_cycle();
        end
        bus.req_valid = '0;
    endtask
`endif

    task automatic test_random();
        int win;
        logic [7:0] want;
        reset_dut();
        for (int u = 0; u < 4; u++) m_cred[u] = UC;
        for (int w = 0; w < NW; w++) m_age[w] = 0;
        m_rr = 0; m_iss_id = 0; m_iss_unit = 0; m_mode = M_RUN;
        m_iss_v = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = 8'($urandom);
            bus.req_unit  = 16'($urandom);
            bus.iss_ready = ($urandom_range(99) < 70);
            for (int u = 0; u < 4; u++)
                bus.cr_ret[u] = ((m_cred[u] < UC) && ($urandom_range(99) < 30)) || ($urandom_range(299) == 0);
            if ($urandom_range(99) < 4) bus.drain_req = !bus.drain_req;
            @(negedge clk);
            win  = m_pick();
            want = (win >= 0) ? (8'h01 << win) : 8'h00;
            n_chk++; if (bus.grant !== want) $display("FAIL rnd_grant c%0d got=%h want=%h", c, bus.grant, want); else n_pass++;
            n_chk++; if (bus.iss_valid !== m_iss_v) $display("FAIL rnd_iss_valid c%0d got=%b want=%b", c, bus.iss_valid, m_iss_v); else n_pass++;
            n_chk++; if (bus.iss_warp_id !== 6'(m_iss_id)) $display("FAIL rnd_iss_id c%0d got=%0d want=%0d", c, bus.iss_warp_id, m_iss_id); else n_pass++;
            n_chk++; if (bus.iss_unit !== 2'(m_iss_unit)) $display("FAIL rnd_iss_unit c%0d got=%0d want=%0d", c, bus.iss_unit, m_iss_unit); else n_pass++;
            n_chk++; if (bus.drain_done !== (m_mode == M_IDLE)) $display("FAIL rnd_drain_done c%0d got=%b want=%b", c, bus.drain_done, m_mode == M_IDLE); else n_pass++;
            n_chk++; if (bus.cr_err !== m_err) $display("FAIL rnd_cr_err c%0d got=%b want=%b", c, bus.cr_err, m_err); else n_pass++;
            m_advance(win);
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_credit_stall();
        test_hold();
        test_credit_same_cycle();
        test_drain();
        test_reset_mid();
`ifdef WARP_ISSUE_AGING_EN
        test_aging();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/warp_issue_arbiter.md
WARP_ISSUE_ARBITER -- requirements
Module: warp_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8: number of warp requesters, 2..32.
REQ-002 SHALL have parameter UNIT_CREDITS, default 4: in-flight issue limit for each of ALU/FPU/LSU/SFU, 1..15.
REQ-003 SHALL have parameter STARVE_LIMIT, default 15: aging threshold in cycles, 1..255.
REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NUM_WARPS  per-warp instruction ready to issue.
REQ-007 SHALL have port req_unit  in  NUM_WARPS*2  per-warp target unit: 0=ALU, 1=FPU, 2=LSU, 3=SFU.
REQ-008 SHALL have port grant  out  NUM_WARPS  one-hot pulse: the warp's request was accepted this cycle.
REQ-009 SHALL have port iss_valid  out  1  issue-unit valid.
REQ-010 SHALL have port iss_warp_id  out  6  granted warp index, zero-extended.
REQ-011 SHALL have port iss_unit  out  2  granted unit code.
REQ-012 SHALL have port iss_ready  in  1  issue unit accepts the held issue.
REQ-013 SHALL have port cr_ret  in  4  one-cycle credit-return pulses, bit i = unit i.
REQ-014 SHALL have port drain_req  in  1  level: stop granting and quiesce.
REQ-015 SHALL have port drain_done  out  1  level: drained and all credits home.
REQ-016 SHALL have port cr_err  out  1  sticky: credit return with counter already full.

Function
REQ-017 SHALL define eligible[w] = req_valid[w] & credit[req_unit[w]] != 0 & state == RUN.
REQ-018 SHALL run the output stage as a register, loadable when !iss_valid | iss_ready.
REQ-019 SHALL grant at most one eligible warp per cycle, only in a loadable cycle.
REQ-020 SHALL pick the winner round-robin, starting the search at rr_ptr.
REQ-021 SHALL set rr_ptr to (winner+1) mod NUM_WARPS after each grant.
REQ-022 SHALL present the winner on iss_* one cycle after grant; iss_valid/iss_warp_id/iss_unit held stable while iss_valid & !iss_ready.
REQ-023 SHALL clear iss_valid on iss_ready when there is no new grant; back-to-back grants give a 1-per-cycle throughput.
REQ-024 SHALL decrement credit[u] on grant to unit u and increment on cr_ret[u]; both in the same cycle leaves it unchanged.
REQ-025 SHALL saturate credit[u] at UNIT_CREDITS and set cr_err when cr_ret[u] arrives at full without a same-cycle grant to u.
REQ-026 SHALL provide FSM states RUN, DRAIN, IDLE: RUN->DRAIN on drain_req; DRAIN->IDLE when !iss_valid & all credits == UNIT_CREDITS; IDLE->RUN on !drain_req; DRAIN->RUN if drain_req drops before IDLE.
REQ-027 SHALL block new grants in DRAIN and IDLE; a held issue still completes.
REQ-028 SHALL drive drain_done high only in IDLE.
REQ-029 SHALL drop a warp's request without a grant when req_valid deasserts; no request is latched.

Reset
REQ-030 SHALL, on rst, set iss_valid=0, iss_warp_id=0, iss_unit=0, grant=0, rr_ptr=0, all credits=UNIT_CREDITS, cr_err=0, state=RUN, drain_done=0, and all age counters=0.
REQ-031 SHALL discard the held issue on rst mid-operation; the issue unit sees iss_valid=0 on the next cycle.

Configuration
REQ-032 SHALL implement starvation aging when WARP_ISSUE_AGING_EN is defined: a per-warp age counter increments while eligible and not granted, clears on grant, and saturates at STARVE_LIMIT.
REQ-033 SHALL, with WARP_ISSUE_AGING_EN defined, have any warp whose age >= STARVE_LIMIT override round-robin, lowest index first, with rr_ptr updated as for a normal grant.
REQ-034 SHALL, without WARP_ISSUE_AGING_EN, use pure round-robin and generate no age counters.

Structure
REQ-035 SHALL take the unit_e enum (ALU/FPU/LSU/SFU) and the arbiter state enum from shared package sm_issue_pkg.
REQ-036 SHALL implement the round-robin selection in one sub-module, rr_pick: combinational, inputs mask and ptr, outputs one-hot and index.

Verification
REQ-037 SHALL verify: all 8 warps valid to ALU, iss_ready=1 -> grants to warps 0,1,2,3, then stall after 4 grants until cr_ret[0] pulses.
REQ-038 SHALL verify: iss_ready=0 for 3 cycles with a held issue -> iss_* stable, no grant, credits unchanged.
REQ-039 SHALL verify: grant to LSU and cr_ret[2] in the same cycle -> credit[LSU] unchanged; cr_ret[3] pulsed at full -> cr_err=1.
REQ-040 SHALL verify: drain_req with 2 credits outstanding -> drain_done rises the cycle after the last cr_ret; drain_req drop -> RUN the next cycle.
REQ-041 SHALL verify: with WARP_ISSUE_AGING_EN, STARVE_LIMIT=3, warp 5 blocked by round-robin pattern -> warp 5 granted within 4 cycles.
REQ-042 SHALL verify: rst asserted while iss_valid=1 -> next cycle iss_valid=0, credits=4, rr_ptr=0.
